// File: rtl/csr_pkg.sv
// Shared encodings for the CSR access sequencer: Zicsr funct3 values, FSM states
// and the read-only CSR address test.
package csr_pkg;

    localparam int XLEN = 32;

    typedef enum logic [2:0] {
        F3_CSRRW  = 3'b001,
        F3_CSRRS  = 3'b010,
        F3_CSRRC  = 3'b011,
        F3_CSRRWI = 3'b101,
        F3_CSRRSI = 3'b110,
        F3_CSRRCI = 3'b111
    } csr_funct3_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_RESP  = 2'd3
    } csr_state_e;

    // Top two address bits set means the CSR is read-only.
    function automatic logic is_read_only(input logic [11:0] addr);
        return (addr & 12'hC00) == 12'hC00;
    endfunction

endpackage

// File: rtl/csr_access_unit_if.sv
// Request/response handshake between execute/writeback and the CSR access unit.
interface csr_access_unit_if;
    import csr_pkg::*;

    logic            req_valid_i;
    logic            req_ready_o;
    logic [2:0]      req_funct3_i;
    logic [11:0]     req_csr_addr_i;
    logic [XLEN-1:0] req_rs1_data_i;
    logic [4:0]      req_rs1_idx_i;
    logic [4:0]      req_rd_idx_i;

    logic            rsp_valid_o;
    logic            rsp_ready_i;
    logic [XLEN-1:0] rsp_data_o;
    logic [4:0]      rsp_rd_idx_o;
    logic            rsp_illegal_o;

    modport slave (
        input  req_valid_i, req_funct3_i, req_csr_addr_i, req_rs1_data_i,
               req_rs1_idx_i, req_rd_idx_i, rsp_ready_i,
        output req_ready_o, rsp_valid_o, rsp_data_o, rsp_rd_idx_o, rsp_illegal_o
    );

    modport master (
        output req_valid_i, req_funct3_i, req_csr_addr_i, req_rs1_data_i,
               req_rs1_idx_i, req_rd_idx_i, rsp_ready_i,
        input  req_ready_o, rsp_valid_o, rsp_data_o, rsp_rd_idx_o, rsp_illegal_o
    );

endinterface

// File: rtl/csr_modify_alu.sv
// Combinational read-modify value and the Zicsr read/write suppression flags.
module csr_modify_alu
    import csr_pkg::*;
(
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] old_i,
    input  logic [XLEN-1:0] rs1_data_i,
    input  logic [4:0]      uimm_i,
    input  logic [4:0]      rd_idx_i,
    output logic [XLEN-1:0] new_o,
    output logic            write_sup_o,
    output logic            read_sup_o
);

    logic [XLEN-1:0] op;

    always_comb begin
        op          = funct3_i[2] ? {{(XLEN-5){1'b0}}, uimm_i} : rs1_data_i;
        new_o       = old_i;
        read_sup_o  = 1'b0;
        // Reserved funct3 values never write.
        write_sup_o = 1'b1;
        case (funct3_i)
            F3_CSRRW, F3_CSRRWI: begin
                read_sup_o  = (rd_idx_i == 5'd0);
                write_sup_o = 1'b0;
                new_o       = op;
            end
            F3_CSRRS, F3_CSRRSI: begin
                write_sup_o = (uimm_i == 5'd0);
                new_o       = old_i | op;
            end
            F3_CSRRC, F3_CSRRCI: begin
                write_sup_o = (uimm_i == 5'd0);
                new_o       = old_i & ~op;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/csr_access_unit.sv
// Sequences one Zicsr instruction through the CSR register file:
// registered read, modify, write, then holds the old value for writeback.
module csr_access_unit
    import csr_pkg::*;
(
    input  logic                    clk_i,
    input  logic                    rst_i,
    csr_access_unit_if.slave        bus,
    input  logic                    flush_i,
    output logic [11:0]             csr_addr_o,
    output logic                    csr_re_o,
    input  logic [XLEN-1:0]         csr_data_i,
    output logic                    csr_we_o,
    output logic [11:0]             csr_waddr_o,
    output logic [31:0]             csr_wdata_o
);

    csr_state_e      state_q, state_d;
    logic [2:0]      funct3_q, funct3_d;
    logic [11:0]     addr_q, addr_d;
    logic [XLEN-1:0] rs1_data_q, rs1_data_d;
    logic [4:0]      rs1_idx_q, rs1_idx_d;
    logic [4:0]      rd_idx_q, rd_idx_d;
    logic            ready_q, ready_d;
    logic            re_q, re_d;
    logic            we_q, we_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [XLEN-1:0] rsp_data_q, rsp_data_d;
    logic [4:0]      rsp_rd_idx_q, rsp_rd_idx_d;
    logic            rsp_illegal_q, rsp_illegal_d;

    logic            accept;
    logic            in_idle;
    logic [2:0]      alu_funct3;
    logic [11:0]     alu_addr;
    logic [XLEN-1:0] alu_rs1_data;
    logic [4:0]      alu_rs1_idx;
    logic [4:0]      alu_rd_idx;
    logic [XLEN-1:0] new_val;
    logic            write_sup;
    logic            read_sup;
    logic            illegal;

    // In IDLE the ALU looks at the incoming request so the suppressed-read path
    // can decide the write enable at acceptance; afterwards it uses the latch.
    assign in_idle      = (state_q == ST_IDLE);
    assign alu_funct3   = in_idle ? bus.req_funct3_i   : funct3_q;
    assign alu_addr     = in_idle ? bus.req_csr_addr_i : addr_q;
    assign alu_rs1_data = in_idle ? bus.req_rs1_data_i : rs1_data_q;
    assign alu_rs1_idx  = in_idle ? bus.req_rs1_idx_i  : rs1_idx_q;
    assign alu_rd_idx   = in_idle ? bus.req_rd_idx_i   : rd_idx_q;

    csr_modify_alu u_alu (
        .funct3_i    (alu_funct3),
        .old_i       (csr_data_i),
        .rs1_data_i  (alu_rs1_data),
        .uimm_i      (alu_rs1_idx),
        .rd_idx_i    (alu_rd_idx),
        .new_o       (new_val),
        .write_sup_o (write_sup),
        .read_sup_o  (read_sup)
    );

    assign illegal = is_read_only(alu_addr) && !write_sup;
    assign accept  = bus.req_valid_i && ready_q && !flush_i;

    always_comb begin
        state_d       = state_q;
        funct3_d      = funct3_q;
        addr_d        = addr_q;
        rs1_data_d    = rs1_data_q;
        rs1_idx_d     = rs1_idx_q;
        rd_idx_d      = rd_idx_q;
        ready_d       = ready_q;
        re_d          = 1'b0;
        we_d          = 1'b0;
        rsp_valid_d   = rsp_valid_q;
        rsp_data_d    = rsp_data_q;
        rsp_rd_idx_d  = rsp_rd_idx_q;
        rsp_illegal_d = rsp_illegal_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    funct3_d   = bus.req_funct3_i;
                    addr_d     = bus.req_csr_addr_i;
                    rs1_data_d = bus.req_rs1_data_i;
                    rs1_idx_d  = bus.req_rs1_idx_i;
                    rd_idx_d   = bus.req_rd_idx_i;
                    ready_d    = 1'b0;
                    if (read_sup) begin
                        state_d = ST_WRITE;
                        we_d    = !write_sup && !illegal;
                    end else begin
                        state_d = ST_READ;
                        re_d    = 1'b1;
                    end
                end
            end
            ST_READ: begin
                if (flush_i) begin
                    state_d = ST_IDLE;
                    ready_d = 1'b1;
                end else begin
                    state_d = ST_WRITE;
                    we_d    = !write_sup && !illegal;
                end
            end
            ST_WRITE: begin
                rsp_data_d    = (read_sup || illegal) ? '0 : csr_data_i;
                rsp_rd_idx_d  = rd_idx_q;
                rsp_illegal_d = illegal;
                rsp_valid_d   = 1'b1;
                state_d       = ST_RESP;
            end
            ST_RESP: begin
                if (bus.rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    ready_d     = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= ST_IDLE;
            funct3_q      <= '0;
            addr_q        <= '0;
            rs1_data_q    <= '0;
            rs1_idx_q     <= '0;
            rd_idx_q      <= '0;
            ready_q       <= 1'b1;
            re_q          <= 1'b0;
            we_q          <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_data_q    <= '0;
            rsp_rd_idx_q  <= '0;
            rsp_illegal_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            funct3_q      <= funct3_d;
            addr_q        <= addr_d;
            rs1_data_q    <= rs1_data_d;
            rs1_idx_q     <= rs1_idx_d;
            rd_idx_q      <= rd_idx_d;
            ready_q       <= ready_d;
            re_q          <= re_d;
            we_q          <= we_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_data_q    <= rsp_data_d;
            rsp_rd_idx_q  <= rsp_rd_idx_d;
            rsp_illegal_q <= rsp_illegal_d;
        end
    end

    assign csr_addr_o  = addr_q;
    assign csr_re_o    = re_q;
    // A reset landing on the WRITE cycle must keep the register file untouched.
    assign csr_we_o    = we_q && !rst_i;
    assign csr_waddr_o = addr_q;
    assign csr_wdata_o = (state_q == ST_WRITE) ? new_val : '0;

    assign bus.req_ready_o   = ready_q;
    assign bus.rsp_valid_o   = rsp_valid_q;
    assign bus.rsp_data_o    = rsp_data_q;
    assign bus.rsp_rd_idx_o  = rsp_rd_idx_q;
    assign bus.rsp_illegal_o = rsp_illegal_q;

endmodule

// File: tb/tb_csr_access_unit.sv
// Randomized and directed bench for csr_access_unit against a register-file
// model and a spec-level reference of the Zicsr read/modify/write rules.
module tb_csr_access_unit;
    import csr_pkg::*;

    typedef struct {
        logic [2:0]  f3;
        logic [11:0] addr;
        logic [31:0] rs1;
        logic [4:0]  rs1_idx;
        logic [4:0]  rd;
    } op_t;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        ill;
        int          lat, t0, re_n, we_n, re_at, we_at;
        logic [31:0] wdata;
        bit          stable, ready_seen, ready_after, timeout;
        int          re_hold;
    } obs_t;

    typedef struct {
        bit          rd_en, wr_en, ill;
        logic [31:0] newv, data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [11:0] csr_addr, csr_waddr;
    logic        csr_re, csr_we;
    logic [31:0] csr_rdata, csr_wdata;

    logic [31:0] rf  [4096];
    logic [31:0] mdl [4096];
    logic        pre_we;
    logic [11:0] pre_addr;
    logic [31:0] pre_data;

    int cyc = 0;
    int re_cnt = 0, we_cnt = 0, both_cnt = 0, re_cyc = 0, we_cyc = 0;
    logic [31:0] we_data = '0;
    int checks = 0, errors = 0;

    csr_access_unit_if u_if();

    csr_access_unit dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .bus         (u_if.slave),
        .flush_i     (flush),
        .csr_addr_o  (csr_addr),
        .csr_re_o    (csr_re),
        .csr_data_i  (csr_rdata),
        .csr_we_o    (csr_we),
        .csr_waddr_o (csr_waddr),
        .csr_wdata_o (csr_wdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Register file: one-cycle registered read, write on csr_we.
    always @(posedge clk) begin
        if (pre_we) rf[pre_addr] <= pre_data;
        else if (csr_we) rf[csr_waddr] <= csr_wdata;
        if (csr_re) csr_rdata <= rf[csr_addr];
    end

    always @(negedge clk) begin
        if (csr_re) begin re_cnt <= re_cnt + 1; re_cyc <= cyc; end
        if (csr_we) begin we_cnt <= we_cnt + 1; we_cyc <= cyc; we_data <= csr_wdata; end
        if (csr_re && csr_we) both_cnt <= both_cnt + 1;
    end

    function automatic op_t mk(logic [2:0] f3, logic [11:0] a, logic [31:0] r, logic [4:0] i, logic [4:0] d);
        op_t o;
        o.f3 = f3; o.addr = a; o.rs1 = r; o.rs1_idx = i; o.rd = d;
        return o;
    endfunction

    // Architectural result of one Zicsr instruction given the current CSR value.
    function automatic exp_t model(op_t op, logic [31:0] cur);
        exp_t e;
        logic [31:0] operand;
        bit is_swap, attempt;
        is_swap = (op.f3[1:0] == 2'b01);
        operand = op.f3[2] ? 32'(op.rs1_idx) : op.rs1;
        e.rd_en = !(is_swap && op.rd == 5'd0);
        attempt = is_swap || (op.rs1_idx != 5'd0);
        e.ill   = (op.addr >= 12'hC00) && attempt;
        e.wr_en = attempt && !e.ill;
        if (is_swap) e.newv = operand;
        else if (op.f3[1:0] == 2'b10) e.newv = cur | operand;
        else e.newv = cur & ~operand;
        e.data = (e.rd_en && !e.ill) ? cur : 32'd0;
        return e;
    endfunction

    task automatic preload(input logic [11:0] a, input logic [31:0] d);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        @(posedge clk); #1;
        pre_we = 1'b0;
        mdl[a] = d;
    endtask

    task automatic drive_req(input op_t op);
        u_if.req_funct3_i   = op.f3;
        u_if.req_csr_addr_i = op.addr;
        u_if.req_rs1_data_i = op.rs1;
        u_if.req_rs1_idx_i  = op.rs1_idx;
        u_if.req_rd_idx_i   = op.rd;
    endtask

    // Runs one instruction; holds rsp_ready low for 'hold' cycles of RESP while
    // offering a competing request that must not be taken.
    task automatic run_op(input op_t op, input int hold, output obs_t o);
        int n, re0, we0, reh;
        o = '{default: 0};
        u_if.rsp_ready_i = 1'b0;
        n = 0;
        while (!u_if.req_ready_o && n < 20) begin @(posedge clk); #1; n++; end
        drive_req(op);
        u_if.req_valid_i = 1'b1;
        o.t0 = cyc; re0 = re_cnt; we0 = we_cnt;
        @(posedge clk); #1;
        u_if.req_valid_i = 1'b0;
        n = 1;
        while (!u_if.rsp_valid_o && n < 10) begin @(posedge clk); #1; n++; end
        o.timeout = !u_if.rsp_valid_o;
        o.lat  = cyc - o.t0;
        o.data = u_if.rsp_data_o; o.rd = u_if.rsp_rd_idx_o; o.ill = u_if.rsp_illegal_o;
        o.stable = 1'b1;
        reh = re_cnt;
        for (int i = 0; i < hold; i++) begin
            u_if.req_valid_i = 1'b1;
            @(posedge clk); #1;
            if (u_if.req_ready_o) o.ready_seen = 1'b1;
            if (!u_if.rsp_valid_o || u_if.rsp_data_o !== o.data ||
                u_if.rsp_rd_idx_o !== o.rd || u_if.rsp_illegal_o !== o.ill) o.stable = 1'b0;
        end
        u_if.req_valid_i = 1'b0;
        o.re_hold = re_cnt - reh;
        u_if.rsp_ready_i = 1'b1;
        @(posedge clk); #1;
        u_if.rsp_ready_i = 1'b0;
        o.ready_after = u_if.req_ready_o;
        o.re_n = re_cnt - re0; o.we_n = we_cnt - we0;
        o.re_at = re_cyc - o.t0; o.we_at = we_cyc - o.t0; o.wdata = we_data;
    endtask

    task automatic test_reset();
        checks++;
        if (u_if.req_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", u_if.req_ready_o); end
        checks++;
        if ({u_if.rsp_valid_o, csr_re, csr_we, u_if.rsp_illegal_o} !== 4'b0) begin
            errors++; $display("FAIL reset_ctrl got %b exp 0000", {u_if.rsp_valid_o, csr_re, csr_we, u_if.rsp_illegal_o}); end
        checks++;
        if ({u_if.rsp_data_o, u_if.rsp_rd_idx_o} !== 37'd0) begin
            errors++; $display("FAIL reset_rsp got %h/%0d exp 0/0", u_if.rsp_data_o, u_if.rsp_rd_idx_o); end
        checks++;
        if ({csr_addr, csr_waddr, csr_wdata} !== 56'd0) begin
            errors++; $display("FAIL reset_csr got %h %h %h exp 0", csr_addr, csr_waddr, csr_wdata); end
    endtask

    task automatic test_set_example();
        obs_t o;
        preload(12'h300, 32'h1800);
        run_op(mk(3'b010, 12'h300, 32'h8, 5'd6, 5'd5), 0, o);
        checks++;
        if (o.re_n != 1 || o.re_at != 1) begin errors++; $display("FAIL rs_re got n=%0d at=%0d exp 1/1", o.re_n, o.re_at); end
        checks++;
        if (o.we_n != 1 || o.we_at != 2) begin errors++; $display("FAIL rs_we got n=%0d at=%0d exp 1/2", o.we_n, o.we_at); end
        checks++;
        if (o.wdata !== 32'h1808) begin errors++; $display("FAIL rs_wdata got %h exp 00001808", o.wdata); end
        checks++;
        if (o.data !== 32'h1800 || o.rd !== 5'd5 || o.lat != 3) begin
            errors++; $display("FAIL rs_rsp got %h rd=%0d lat=%0d exp 00001800 rd=5 lat=3", o.data, o.rd, o.lat); end
        mdl[12'h300] = 32'h1808;
    endtask

    task automatic test_rw_rd0();
        obs_t o;
        run_op(mk(3'b001, 12'h305, 32'h80000100, 5'd7, 5'd0), 0, o);
        checks++;
        if (o.re_n != 0) begin errors++; $display("FAIL rw0_re got %0d exp 0", o.re_n); end
        checks++;
        if (o.we_n != 1 || o.we_at != 1 || o.wdata !== 32'h80000100) begin
            errors++; $display("FAIL rw0_we got n=%0d at=%0d d=%h exp 1/1/80000100", o.we_n, o.we_at, o.wdata); end
        checks++;
        if (o.lat != 2 || o.data !== 32'd0) begin errors++; $display("FAIL rw0_rsp got lat=%0d d=%h exp 2/0", o.lat, o.data); end
        mdl[12'h305] = 32'h80000100;
    endtask

    task automatic test_rci_zero();
        obs_t o;
        preload(12'h300, 32'hFF);
        run_op(mk(3'b111, 12'h300, 32'hFFFF_FFFF, 5'd0, 5'd3), 0, o);
        checks++;
        if (o.we_n != 0) begin errors++; $display("FAIL rci0_we got %0d exp 0", o.we_n); end
        checks++;
        if (o.data !== 32'hFF || o.rd !== 5'd3) begin errors++; $display("FAIL rci0_rsp got %h rd=%0d exp 000000ff rd=3", o.data, o.rd); end
    endtask

    task automatic test_illegal();
        obs_t o;
        preload(12'hC00, 32'h1234);
        run_op(mk(3'b001, 12'hC00, 32'hDEAD, 5'd2, 5'd1), 0, o);
        checks++;
        if (o.we_n != 0 || o.ill !== 1'b1 || o.data !== 32'd0) begin
            errors++; $display("FAIL ill_rw got we=%0d ill=%b d=%h exp 0/1/0", o.we_n, o.ill, o.data); end
        run_op(mk(3'b010, 12'hC00, 32'hFFFF, 5'd0, 5'd1), 0, o);
        checks++;
        if (o.ill !== 1'b0 || o.data !== 32'h1234 || o.we_n != 0) begin
            errors++; $display("FAIL ill_rs0 got ill=%b d=%h we=%0d exp 0/00001234/0", o.ill, o.data, o.we_n); end
        checks++;
        if (rf[12'hC00] !== 32'h1234) begin errors++; $display("FAIL ill_rf got %h exp 00001234", rf[12'hC00]); end
    endtask

    task automatic test_backpressure();
        obs_t o;
        exp_t e;
        op_t op;
        op = mk(3'b011, 12'h341, 32'h0F0F, 5'd9, 5'd12);
        preload(12'h341, 32'hFFFF_0FF0);
        e = model(op, mdl[12'h341]);
        run_op(op, 5, o);
        checks++;
        if (!o.stable || o.data !== e.data || o.rd !== 5'd12) begin
            errors++; $display("FAIL bp_rsp got st=%0b d=%h exp st=1 d=%h", o.stable, o.data, e.data); end
        checks++;
        if (o.ready_seen || o.re_hold != 0) begin
            errors++; $display("FAIL bp_accept got ready=%0b re=%0d exp 0/0", o.ready_seen, o.re_hold); end
        checks++;
        if (!o.ready_after) begin errors++; $display("FAIL bp_ready_after got 0 exp 1"); end
        mdl[12'h341] = e.newv;
        checks++;
        if (rf[12'h341] !== mdl[12'h341]) begin errors++; $display("FAIL bp_rf got %h exp %h", rf[12'h341], mdl[12'h341]); end
    endtask

    task automatic test_back_to_back();
        obs_t a, b;
        run_op(mk(3'b010, 12'h300, 32'h1, 5'd4, 5'd2), 0, a);
        run_op(mk(3'b010, 12'h300, 32'h2, 5'd4, 5'd2), 0, b);
        checks++;
        if (b.t0 - a.t0 != 4) begin errors++; $display("FAIL b2b_rate got %0d exp 4", b.t0 - a.t0); end
        checks++;
        if (b.data !== (mdl[12'h300] | 32'h1)) begin errors++; $display("FAIL b2b_data got %h exp %h", b.data, mdl[12'h300] | 32'h1); end
        mdl[12'h300] = mdl[12'h300] | 32'h3;
        run_op(mk(3'b101, 12'h305, 32'h0, 5'd17, 5'd0), 0, a);
        run_op(mk(3'b101, 12'h305, 32'h0, 5'd18, 5'd0), 0, b);
        checks++;
        if (b.t0 - a.t0 != 3) begin errors++; $display("FAIL b2b_rate_nr got %0d exp 3", b.t0 - a.t0); end
        mdl[12'h305] = 32'd18;
        checks++;
        if (rf[12'h305] !== 32'd18) begin errors++; $display("FAIL b2b_rf got %h exp 00000012", rf[12'h305]); end
    endtask

    task automatic test_flush();
        int re0, we0;
        bit seen_valid;
        re0 = re_cnt; we0 = we_cnt;
        drive_req(mk(3'b010, 12'h300, 32'hF0, 5'd6, 5'd5));
        flush = 1'b1; u_if.req_valid_i = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; u_if.req_valid_i = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (re_cnt != re0 || !u_if.req_ready_o) begin
            errors++; $display("FAIL flush_idle got re=%0d ready=%b exp 0/1", re_cnt - re0, u_if.req_ready_o); end
        u_if.req_valid_i = 1'b1;
        @(posedge clk); #1;
        u_if.req_valid_i = 1'b0; flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        checks++;
        if (!u_if.req_ready_o) begin errors++; $display("FAIL flush_read_idle got ready=0 exp 1"); end
        seen_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (u_if.rsp_valid_o) seen_valid = 1'b1;
        end
        checks++;
        if (we_cnt != we0 || seen_valid || re_cnt != re0 + 1) begin
            errors++; $display("FAIL flush_read got we=%0d valid=%0b re=%0d exp 0/0/1", we_cnt - we0, seen_valid, re_cnt - re0); end
        checks++;
        if (rf[12'h300] !== mdl[12'h300]) begin errors++; $display("FAIL flush_rf got %h exp %h", rf[12'h300], mdl[12'h300]); end
    endtask

    task automatic test_reset_in_write();
        drive_req(mk(3'b001, 12'h305, 32'hABCD_0001, 5'd3, 5'd0));
        u_if.req_valid_i = 1'b1;
        @(posedge clk); #1;
        u_if.req_valid_i = 1'b0;
        checks++;
        if (csr_we !== 1'b1) begin errors++; $display("FAIL rstw_in_write got we=%b exp 1", csr_we); end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        test_reset();
        checks++;
        if (rf[12'h305] !== mdl[12'h305]) begin errors++; $display("FAIL rstw_rf got %h exp %h", rf[12'h305], mdl[12'h305]); end
    endtask

    task automatic test_random();
        logic [2:0]  f3_tbl [6];
        logic [11:0] a_tbl  [6];
        op_t  op;
        obs_t o;
        exp_t e;
        f3_tbl = '{3'b001, 3'b010, 3'b011, 3'b101, 3'b110, 3'b111};
        a_tbl  = '{12'h300, 12'h305, 12'h341, 12'h7C0, 12'hC00, 12'hF11};
        foreach (a_tbl[k]) preload(a_tbl[k], $urandom);
        for (int i = 0; i < 40; i++) begin
            op.f3      = f3_tbl[$urandom_range(0, 5)];
            op.addr    = a_tbl[$urandom_range(0, 5)];
            op.rs1     = $urandom;
            op.rs1_idx = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            op.rd      = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            e = model(op, mdl[op.addr]);
            run_op(op, $urandom_range(0, 2), o);
            if (e.wr_en) mdl[op.addr] = e.newv;
            checks++;
            if (o.timeout || o.lat != (e.rd_en ? 3 : 2)) begin
                errors++; $display("FAIL rnd%0d_lat got %0d to=%0b exp %0d", i, o.lat, o.timeout, e.rd_en ? 3 : 2); end
            checks++;
            if (o.data !== e.data || o.ill !== e.ill || o.rd !== op.rd || !o.stable) begin
                errors++; $display("FAIL rnd%0d_rsp got %h ill=%b rd=%0d exp %h ill=%b rd=%0d", i, o.data, o.ill, o.rd, e.data, e.ill, op.rd); end
            checks++;
            if (o.re_n != int'(e.rd_en) || o.we_n != int'(e.wr_en)) begin
                errors++; $display("FAIL rnd%0d_pulses got re=%0d we=%0d exp %0d/%0d", i, o.re_n, o.we_n, e.rd_en, e.wr_en); end
            checks++;
            if (rf[op.addr] !== mdl[op.addr]) begin
                errors++; $display("FAIL rnd%0d_rf got %h exp %h", i, rf[op.addr], mdl[op.addr]); end
        end
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; pre_we = 1'b0; pre_addr = '0; pre_data = '0;
        u_if.req_valid_i = 1'b0; u_if.rsp_ready_i = 1'b0;
        drive_req(mk(3'b000, 12'h0, 32'h0, 5'd0, 5'd0));
        for (int i = 0; i < 4096; i++) mdl[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rst = 1'b0;
        test_set_example();
        test_rw_rd0();
        test_rci_zero();
        test_illegal();
        test_backpressure();
        test_back_to_back();
        test_flush();
        test_random();
        test_reset_in_write();
        checks++;
        if (both_cnt != 0) begin errors++; $display("FAIL re_we_overlap got %0d exp 0", both_cnt); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
